// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response bundle linking fetch port, load/store port, arbiter and memory
// Parameters: ADDR_W address width, DATA_W data width
// Modports: slave = arbiter view (takes requests and mem_rdata, drives responses, stalls and memory controls)
//           master = pipeline/memory view (drives requests and mem_rdata, observes everything else)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_funct3;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              stall_if;
   logic              stall_mem;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_funct3;
   logic [DATA_W-1:0] mem_rdata;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
             mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
             mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port and the load/store port
// Ports: clk rising-edge clock; reset async active-high; bus (slave modport) carries the fetch
//        request/response, data request/response, per-stage stalls and the memory interface.
// Data requests win ties unless the fetch has already lost STARVE_MAX consecutive ties.
module mem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 2
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int LW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
   state_t            state_q;
   logic [LW-1:0]     lat_cnt_q;
   logic [SW-1:0]     starve_cnt_q;
   logic              en_q, we_q, if_ready_q, d_ready_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, d_rdata_q;
   logic [2:0]        f3_q;
   logic [31:0]       if_rdata_q;
   logic              starved, grant_i;
   assign starved = starve_cnt_q == SW'(STARVE_MAX);
   assign grant_i = bus.if_req & (~bus.d_req | starved);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         en_q         <= 1'b0;
         we_q         <= 1'b0;
         if_ready_q   <= 1'b0;
         d_ready_q    <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         f3_q         <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         case (state_q)
            IDLE: if (bus.if_req | bus.d_req) begin
               state_q   <= grant_i ? BUSY_I : BUSY_D;
               en_q      <= 1'b1;
               we_q      <= ~grant_i & bus.d_we;
               addr_q    <= grant_i ? bus.if_addr : bus.d_addr;
               wdata_q   <= grant_i ? '0 : bus.d_wdata;
               f3_q      <= grant_i ? 3'b010 : bus.d_funct3;
               lat_cnt_q <= '0;
               // counts data grants that overtook a waiting fetch
               starve_cnt_q <= (grant_i | ~bus.if_req) ? '0
                             : starved ? starve_cnt_q : starve_cnt_q + 1'b1;
            end
            BUSY_I, BUSY_D: begin
               lat_cnt_q <= lat_cnt_q + 1'b1;
               if (lat_cnt_q == LW'(MEM_LAT - 1)) begin
                  state_q <= RESP;
                  en_q    <= 1'b0;
                  we_q    <= 1'b0;
                  if (state_q == BUSY_I) begin
                     if_rdata_q <= bus.mem_rdata[31:0];
                     if_ready_q <= 1'b1;
                  end else begin
                     if (!we_q) d_rdata_q <= bus.mem_rdata;
                     d_ready_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.mem_en     = en_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.mem_funct3 = f3_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.if_ready   = if_ready_q;
   assign bus.d_ready    = d_ready_q;
   assign bus.stall_if   = bus.if_req & ~if_ready_q;
   assign bus.stall_mem  = bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus multi-cycle sequences for mem_port_arbiter
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();
   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   function automatic logic [63:0] rd(input logic [63:0] a);
      return a == 64'h10 ? 64'h00A00093 : {32'hCAFE0000, a[31:0] ^ 32'h5};
   endfunction
   assign bus.mem_rdata = rd(bus.mem_addr);
   typedef struct {
      logic ir; logic [63:0] ia; logic dr; logic dw; logic [63:0] da; logic [63:0] dwd; logic [2:0] f3;
      logic en; logic we; logic [63:0] ma; logic [63:0] mwd; logic [2:0] mf3;
      logic iro; logic dro; logic si; logic sm; logic [31:0] ird; logic [63:0] drd;
   } vec_t;
   vec_t v[15];
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic drive(input logic ir, input logic [63:0] ia, input logic dr, input logic dw,
                        input logic [63:0] da, input logic [63:0] dwd, input logic [2:0] f3);
      bus.if_req = ir; bus.if_addr = ia; bus.d_req = dr; bus.d_we = dw;
      bus.d_addr = da; bus.d_wdata = dwd; bus.d_funct3 = f3;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      v[0]  = '{'1, 64'h10, '0, '0, '0, '0, '0,  '0, '0, '0, '0, '0,  '0, '0, '1, '0, '0, '0};
      v[1]  = '{'1, 64'h10, '0, '0, '0, '0, '0,  '1, '0, 64'h10, '0, 3'b010,  '0, '0, '1, '0, '0, '0};
      v[2]  = v[1];
      v[3]  = '{'1, 64'h10, '0, '0, '0, '0, '0,  '0, '0, '0, '0, '0,  '1, '0, '0, '0, 32'h00A00093, '0};
      v[4]  = '{'0, '0, '0, '0, '0, '0, '0,  '0, '0, '0, '0, '0,  '0, '0, '0, '0, 32'h00A00093, '0};
      v[5]  = '{'0, '0, '1, '1, 64'h100, 64'hDEADBEEF, 3'd3,  '0, '0, '0, '0, '0,  '0, '0, '0, '1, 32'h00A00093, '0};
      v[6]  = '{'0, '0, '1, '1, 64'h100, 64'hDEADBEEF, 3'd3,  '1, '1, 64'h100, 64'hDEADBEEF, 3'd3,  '0, '0, '0, '1, 32'h00A00093, '0};
      v[7]  = v[6];
      v[8]  = '{'0, '0, '1, '1, 64'h100, 64'hDEADBEEF, 3'd3,  '0, '0, '0, '0, '0,  '0, '1, '0, '0, 32'h00A00093, '0};
      v[9]  = '{'0, '0, '0, '0, '0, '0, '0,  '0, '0, '0, '0, '0,  '0, '0, '0, '0, 32'h00A00093, '0};
      v[10] = '{'0, '0, '1, '0, 64'h100, '0, 3'd3,  '0, '0, '0, '0, '0,  '0, '0, '0, '1, 32'h00A00093, '0};
      v[11] = '{'0, '0, '1, '0, 64'h180, '0, 3'd3,  '1, '0, 64'h100, '0, 3'd3,  '0, '0, '0, '1, 32'h00A00093, '0};
      v[12] = v[11];
      v[13] = '{'0, '0, '1, '0, 64'h180, '0, 3'd3,  '0, '0, '0, '0, '0,  '0, '1, '0, '0, 32'h00A00093, 64'hCAFE000000000105};
      v[14] = '{'0, '0, '0, '0, '0, '0, '0,  '0, '0, '0, '0, '0,  '0, '0, '0, '0, 32'h00A00093, 64'hCAFE000000000105};
      drive('0, '0, '0, '0, '0, '0, '0);
      #2;
      chk("reset_mem_en", 64'(bus.mem_en), 64'h0);
      chk("reset_mem_we", 64'(bus.mem_we), 64'h0);
      chk("reset_mem_addr", bus.mem_addr, 64'h0);
      chk("reset_readys", 64'({bus.if_ready, bus.d_ready}), 64'h0);
      chk("reset_if_rdata", 64'(bus.if_rdata), 64'h0);
      chk("reset_d_rdata", bus.d_rdata, 64'h0);
      @(negedge clk) reset = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) begin
         drive(v[i].ir, v[i].ia, v[i].dr, v[i].dw, v[i].da, v[i].dwd, v[i].f3);
         @(negedge clk);
         chk($sformatf("vec%0d_mem_en", i), 64'(bus.mem_en), 64'(v[i].en));
         chk($sformatf("vec%0d_mem_we", i), 64'(bus.mem_we), 64'(v[i].we));
         if (v[i].en) begin
            chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, v[i].ma);
            chk($sformatf("vec%0d_mem_funct3", i), 64'(bus.mem_funct3), 64'(v[i].mf3));
         end
         if (v[i].we) chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, v[i].mwd);
         chk($sformatf("vec%0d_if_ready", i), 64'(bus.if_ready), 64'(v[i].iro));
         chk($sformatf("vec%0d_d_ready", i), 64'(bus.d_ready), 64'(v[i].dro));
         chk($sformatf("vec%0d_stall_if", i), 64'(bus.stall_if), 64'(v[i].si));
         chk($sformatf("vec%0d_stall_mem", i), 64'(bus.stall_mem), 64'(v[i].sm));
         chk($sformatf("vec%0d_if_rdata", i), 64'(bus.if_rdata), 64'(v[i].ird));
         chk($sformatf("vec%0d_d_rdata", i), bus.d_rdata, v[i].drd);
         tick();
      end
      // reset in the middle of a fetch
      drive('1, 64'h20, '0, '0, '0, '0, '0);
      tick();
      chk("rst_pre_mem_en", 64'(bus.mem_en), 64'h1);
      #2;
      reset = 1'b1;
      bus.if_req = 1'b0;
      #1;
      chk("rst_mem_en_drop", 64'(bus.mem_en), 64'h0);
      chk("rst_if_rdata", 64'(bus.if_rdata), 64'h0);
      @(negedge clk) reset = 1'b0;
      tick();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rst_idle%0d_readys", c), 64'({bus.if_ready, bus.d_ready}), 64'h0);
         chk($sformatf("rst_idle%0d_mem_en", c), 64'(bus.mem_en), 64'h0);
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         drive(c <= 3, 64'h20, '0, '0, '0, '0, '0);
         @(negedge clk);
         chk($sformatf("refetch_c%0d_if_ready", c), 64'(bus.if_ready), 64'(c == 3));
         chk($sformatf("refetch_c%0d_mem_en", c), 64'(bus.mem_en), 64'(c == 1 || c == 2));
         tick();
      end
      chk("refetch_if_rdata", 64'(bus.if_rdata), 64'h25);
      // simultaneous requests: data first, then fetch
      for (int c = 0; c < 9; c++) begin
         drive(c <= 7, 64'h30, c <= 3, '0, 64'h200, '0, 3'd3);
         @(negedge clk);
         chk($sformatf("simul_c%0d_d_ready", c), 64'(bus.d_ready), 64'(c == 3));
         chk($sformatf("simul_c%0d_if_ready", c), 64'(bus.if_ready), 64'(c == 7));
         chk($sformatf("simul_c%0d_stall_if", c), 64'(bus.stall_if), 64'(c <= 6));
         chk($sformatf("simul_c%0d_mem_en", c), 64'(bus.mem_en), 64'(c == 1 || c == 2 || c == 5 || c == 6));
         tick();
      end
      chk("simul_d_rdata", bus.d_rdata, 64'hCAFE000000000205);
      chk("simul_if_rdata", 64'(bus.if_rdata), 64'h35);
      // starvation guard: both held high gives D, D, I, D, D, I
      for (int c = 0; c < 25; c++) begin
         drive(c <= 23, 64'h40, c <= 23, '0, 64'h300, '0, 3'd3);
         @(negedge clk);
         chk($sformatf("starve_c%0d_d_ready", c), 64'(bus.d_ready), 64'(c == 3 || c == 7 || c == 15 || c == 19));
         chk($sformatf("starve_c%0d_if_ready", c), 64'(bus.if_ready), 64'(c == 11 || c == 23));
         tick();
      end
      chk("starve_if_rdata", 64'(bus.if_rdata), 64'h45);
      chk("starve_d_rdata", bus.d_rdata, 64'hCAFE000000000305);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
